hdlc_rx_checker: RTL
====================

# hdlc_rx_checker

Synthesizable, parametrised protocol checker for the HDLC receiver. It watches the serial `Rx` line and the receiver status strobes. It checks flag-detect, abort-signal and end-of-frame timing at configurable latencies, and optionally flags spurious strobes. It keeps per-class saturating error counters plus frame and abort statistics. It sits beside the Rx module in the testbench and in emulation builds, and replaces the hand-written concurrent assertions.

## Interface
Parameters:
- `FLAG_LAT`, 2: cycles from last flag bit on `Rx` to required `Rx_FlagDetect` (≥1)
- `ABORT_LAT`, 1: cycles from `Rx_AbortDetect && Rx_ValidFrame` to required `Rx_AbortSignal` (≥1)
- `EOF_LAT`, 5: cycles from `Rx_FlagDetect && Rx_ValidFrame` to required `Rx_EoF` (≥1)
- `CNT_W`, 16: width of all counters
- `STRICT`, 0: 1 = also count strobes with no pending expectation

Ports:
- `Clk` in 1: clock, all sampling on rising edge
- `Rst` in 1: asynchronous, active-low reset
- `En` in 1: check enable; 0 = no errors recorded, pipelines and FSM still run
- `Clear` in 1: synchronous clear of all counters
- `Rx` in 1: serial receive line
- `Rx_FlagDetect`, `Rx_AbortDetect`, `Rx_ValidFrame`, `Rx_AbortSignal`, `Rx_EoF` in 1 each: DUT status
- `ErrVec` out 6: registered per-cycle error bits, {SPUR_EOF, SPUR_ABORT, SPUR_FLAG, MISS_EOF, MISS_ABORT, MISS_FLAG}
- `ErrFlagCnt`, `ErrAbortCnt`, `ErrEoFCnt` out CNT_W: miss+spurious count per class
- `ErrCnt` out CNT_W: total errors
- `FrameCnt`, `AbortCnt` out CNT_W: completed frames and aborted frames seen on `Rx`

## Operation
- History register `hist[7:0]` shifts in `Rx` each cycle. `hist[0]` is newest, `hist[7]` is oldest. Reset value 8'hFF.
- Patterns, matched on the current cycle's `{hist[6:0],Rx}`: FLAG = 8'h7E, ABORT = 8'h7F, IDLE = 8'hFF. Overlapping flags sharing a zero are each matched.
- Expectation pipelines, one per class, each a delay line of length LAT:
  - Flag: a FLAG match injects a 1.
  - Abort: `Rx_AbortDetect && Rx_ValidFrame` injects a 1.
  - EoF: `Rx_FlagDetect && Rx_ValidFrame` injects a 1.
- Compare at pipeline output `due`:
  - `due && !strobe` gives MISS.
  - `STRICT && strobe && !due` gives SPUR.
- Overlapping expectations are independent. Each pending bit is checked exactly once.
- Errors are recorded only when `En`=1.
- Frame FSM:
  - HUNT: FLAG goes to OPEN.
  - OPEN: FLAG stays OPEN. Any other bit goes to DATA.
  - DATA: FLAG increments FrameCnt and goes to OPEN. ABORT increments AbortCnt and goes to HUNT. IDLE goes to HUNT.
  - Bit-level abort/idle precedence: ABORT is checked before IDLE.
- Counters saturate at all-ones and never wrap.
- ErrCnt adds the popcount of the recorded error vector, saturating.
- `Clear` zeroes all counters and `ErrVec`. It does not touch the FSM, history or pipelines. `Clear` wins over a same-cycle increment.

## Timing
- Reset (Rst=0, asynchronous): hist=8'hFF, all pipelines 0, FSM=HUNT, every output 0.
- Errors occur in cycle t when `due` and the strobe are compared. `ErrVec` shows them after edge t+1, as a single-cycle pulse per error. Counters update on the same edge.
- FLAG match in cycle t requires `Rx_FlagDetect`=1 in cycle t+FLAG_LAT.
- An injected abort or EoF expectation in cycle t requires its strobe in cycle t+ABORT_LAT or t+EOF_LAT respectively.
- Reset mid-frame discards all pending expectations. No MISS is reported for them.
- `En` falling does not flush pipelines. Expectations that come due while `En`=0 are dropped silently.

## Structure
- Package `hdlc_chk_pkg`:
  - pattern constants FLAG/ABORT/IDLE
  - FSM enum {HUNT, OPEN, DATA}
  - error-bit index constants for `ErrVec`
  - a saturating-add function
- Sub-module `hdlc_chk_delay` (parameter LAT): 1-bit delay line with async active-low reset, instantiated three times.
- Top module: history register, pattern match, FSM, compare logic, counters.

## Test plan
- Rx bits 0,1,1,1,1,1,1,0 with DUT model asserting `Rx_FlagDetect` 2 cycles later: ErrCnt=0. Model held low instead: ErrVec[0] pulses once, ErrFlagCnt=1.
- Two back-to-back flags (01111110111111 0): two expectations; DUT asserts only the first, giving exactly one MISS_FLAG.
- `Rx_AbortDetect`=`Rx_ValidFrame`=1 for one cycle with `Rx_AbortSignal` held 0: MISS_ABORT one cycle later, ErrAbortCnt=1. Same stimulus with `Rx_ValidFrame`=0: no error.
- Flag, 16 data bits, flag on `Rx`: FrameCnt=1. Flag, 10 data bits, 0+seven 1s: AbortCnt=1, FSM=HUNT.
- STRICT=1 with `Rx_EoF` pulsed without an expectation: SPUR_EOF, ErrEoFCnt=1. CNT_W=4 with 20 forced misses: ErrCnt stays at 15.
- Assert Rst 1 cycle after a FLAG match: all outputs 0 immediately, no MISS afterwards. `Clear` during a miss cycle: counters read 0.

Source files
------------

// File: rtl/hdlc_chk_pkg.sv
// Shared definitions for the HDLC receive-side protocol checker.
//   - Rx bit patterns recognised on the serial line (flag, abort, idle)
//   - frame-tracking FSM state type
//   - bit positions inside the ErrVec output
//   - saturating add used by every statistics counter
package hdlc_chk_pkg;

  localparam logic [7:0] PatFlag  = 8'h7E;
  localparam logic [7:0] PatAbort = 8'h7F;
  localparam logic [7:0] PatIdle  = 8'hFF;

  typedef enum logic [1:0] {
    StHunt,
    StOpen,
    StData
  } frame_st_e;

  localparam int unsigned ErrMissFlag  = 0;
  localparam int unsigned ErrMissAbort = 1;
  localparam int unsigned ErrMissEof   = 2;
  localparam int unsigned ErrSpurFlag  = 3;
  localparam int unsigned ErrSpurAbort = 4;
  localparam int unsigned ErrSpurEof   = 5;
  localparam int unsigned NumErr       = 6;

  // a + b clipped to max_val; the 33-bit sum keeps a 32-bit counter from wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/hdlc_chk_delay.sv
// One-bit expectation delay line for the HDLC checker.
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-low reset, clears every stage
//   Din  : expectation injected this cycle
//   Due  : expectation injected LAT cycles ago, now to be compared
module hdlc_chk_delay #(
  parameter int unsigned LAT = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Din,
  output logic Due
);

  logic [LAT-1:0] pipe_q;

  if (LAT == 1) begin : g_single
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= Din;
      end
    end
  end else begin : g_multi
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= {pipe_q[LAT-2:0], Din};
      end
    end
  end

  assign Due = pipe_q[LAT-1];

endmodule

// File: rtl/hdlc_rx_checker.sv
// Protocol checker sitting beside the HDLC receiver.
// Watches the serial line and the receiver status strobes, checks that flag
// detect, abort signal and end-of-frame arrive at fixed latencies, and keeps
// saturating error / frame / abort statistics.
//   Clk, Rst        : clock and asynchronous active-low reset
//   En              : record errors when 1 (pipelines and FSM always run)
//   Clear           : synchronous clear of all counters and ErrVec
//   Rx              : serial receive line
//   Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal, Rx_EoF
//                   : receiver status strobes under check
//   ErrVec          : registered error pulses
//                     {SPUR_EOF, SPUR_ABORT, SPUR_FLAG, MISS_EOF, MISS_ABORT, MISS_FLAG}
//   ErrFlagCnt, ErrAbortCnt, ErrEoFCnt : per-class error counts
//   ErrCnt          : total error count
//   FrameCnt, AbortCnt : frames closed by a flag / aborted, seen on Rx
module hdlc_rx_checker
  import hdlc_chk_pkg::*;
#(
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned ABORT_LAT = 1,
  parameter int unsigned EOF_LAT   = 5,
  parameter int unsigned CNT_W     = 16,
  parameter bit          STRICT    = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Clear,
  input  logic             Rx,
  input  logic             Rx_FlagDetect,
  input  logic             Rx_AbortDetect,
  input  logic             Rx_ValidFrame,
  input  logic             Rx_AbortSignal,
  input  logic             Rx_EoF,
  output logic [5:0]       ErrVec,
  output logic [CNT_W-1:0] ErrFlagCnt,
  output logic [CNT_W-1:0] ErrAbortCnt,
  output logic [CNT_W-1:0] ErrEoFCnt,
  output logic [CNT_W-1:0] ErrCnt,
  output logic [CNT_W-1:0] FrameCnt,
  output logic [CNT_W-1:0] AbortCnt
);

  localparam logic [31:0] CntMax = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                 : ((32'd1 << CNT_W) - 32'd1);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                            input logic [31:0]      inc);
    return CNT_W'(sat_add(32'(cnt), inc, CntMax));
  endfunction

  // ---------------------------------------------------------------------------
  // History and pattern match. Only the seven newest bits are stored: the
  // oldest history bit never reaches the 8-bit match window.
  // ---------------------------------------------------------------------------
  logic [6:0] hist_q;
  logic [7:0] win;
  logic       is_flag, is_abort, is_idle;

  assign win      = {hist_q, Rx};
  assign is_flag  = (win == PatFlag);
  assign is_abort = (win == PatAbort);
  assign is_idle  = (win == PatIdle);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hist_q <= '1;
    end else begin
      hist_q <= win[6:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Expectation pipelines
  // ---------------------------------------------------------------------------
  logic flag_due, abort_due, eof_due;

  hdlc_chk_delay #(.LAT(FLAG_LAT)) u_flag_dly (
    .Clk (Clk),
    .Rst (Rst),
    .Din (is_flag),
    .Due (flag_due)
  );

  hdlc_chk_delay #(.LAT(ABORT_LAT)) u_abort_dly (
    .Clk (Clk),
    .Rst (Rst),
    .Din (Rx_AbortDetect & Rx_ValidFrame),
    .Due (abort_due)
  );

  hdlc_chk_delay #(.LAT(EOF_LAT)) u_eof_dly (
    .Clk (Clk),
    .Rst (Rst),
    .Din (Rx_FlagDetect & Rx_ValidFrame),
    .Due (eof_due)
  );

  // ---------------------------------------------------------------------------
  // Compare: one due bit per class is judged against its strobe exactly once.
  // ---------------------------------------------------------------------------
  logic [2:0]        due, strobe;
  logic [NumErr-1:0] err_raw, err_rec;

  assign due    = {eof_due, abort_due, flag_due};
  assign strobe = {Rx_EoF, Rx_AbortSignal, Rx_FlagDetect};

  assign err_raw[2:0] = due & ~strobe;
  assign err_raw[5:3] = STRICT ? (strobe & ~due) : 3'b000;
  assign err_rec      = En ? err_raw : '0;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  frame_st_e state_q, state_d;
  logic      frame_inc, abort_inc;

  always_comb begin
    state_d   = state_q;
    frame_inc = 1'b0;
    abort_inc = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (is_flag) state_d = StOpen;
      end
      StOpen: begin
        if (!is_flag) state_d = StData;
      end
      StData: begin
        // Abort outranks idle: 0+seven 1s is an abort, not the start of idle.
        if (is_flag) begin
          frame_inc = 1'b1;
          state_d   = StOpen;
        end else if (is_abort) begin
          abort_inc = 1'b1;
          state_d   = StHunt;
        end else if (is_idle) begin
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Error vector and statistics counters; Clear beats any increment.
  // ---------------------------------------------------------------------------
  logic [NumErr-1:0] err_vec_q, err_vec_d;
  logic [CNT_W-1:0]  err_flag_cnt_q, err_flag_cnt_d;
  logic [CNT_W-1:0]  err_abort_cnt_q, err_abort_cnt_d;
  logic [CNT_W-1:0]  err_eof_cnt_q, err_eof_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  abort_cnt_q, abort_cnt_d;

  always_comb begin
    err_vec_d       = err_rec;
    err_flag_cnt_d  = err_flag_cnt_q;
    err_abort_cnt_d = err_abort_cnt_q;
    err_eof_cnt_d   = err_eof_cnt_q;
    err_cnt_d       = err_cnt_q;
    frame_cnt_d     = frame_cnt_q;
    abort_cnt_d     = abort_cnt_q;
    if (Clear) begin
      err_vec_d       = '0;
      err_flag_cnt_d  = '0;
      err_abort_cnt_d = '0;
      err_eof_cnt_d   = '0;
      err_cnt_d       = '0;
      frame_cnt_d     = '0;
      abort_cnt_d     = '0;
    end else begin
      // Miss and spurious of one class are mutually exclusive, so +2 never occurs.
      err_flag_cnt_d  = bump(err_flag_cnt_q,
                             32'(err_rec[ErrMissFlag]) + 32'(err_rec[ErrSpurFlag]));
      err_abort_cnt_d = bump(err_abort_cnt_q,
                             32'(err_rec[ErrMissAbort]) + 32'(err_rec[ErrSpurAbort]));
      err_eof_cnt_d   = bump(err_eof_cnt_q,
                             32'(err_rec[ErrMissEof]) + 32'(err_rec[ErrSpurEof]));
      err_cnt_d       = bump(err_cnt_q, 32'($countones(err_rec)));
      frame_cnt_d     = bump(frame_cnt_q, 32'(frame_inc));
      abort_cnt_d     = bump(abort_cnt_q, 32'(abort_inc));
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      err_vec_q       <= '0;
      err_flag_cnt_q  <= '0;
      err_abort_cnt_q <= '0;
      err_eof_cnt_q   <= '0;
      err_cnt_q       <= '0;
      frame_cnt_q     <= '0;
      abort_cnt_q     <= '0;
    end else begin
      err_vec_q       <= err_vec_d;
      err_flag_cnt_q  <= err_flag_cnt_d;
      err_abort_cnt_q <= err_abort_cnt_d;
      err_eof_cnt_q   <= err_eof_cnt_d;
      err_cnt_q       <= err_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      abort_cnt_q     <= abort_cnt_d;
    end
  end

  assign ErrVec      = err_vec_q;
  assign ErrFlagCnt  = err_flag_cnt_q;
  assign ErrAbortCnt = err_abort_cnt_q;
  assign ErrEoFCnt   = err_eof_cnt_q;
  assign ErrCnt      = err_cnt_q;
  assign FrameCnt    = frame_cnt_q;
  assign AbortCnt    = abort_cnt_q;

endmodule
